// File: rtl/life_grid_seq.sv
// rtl/life_grid_seq.sv - time-multiplexed Game-of-Life grid sequencer
//
// Steps a W x H Game-of-Life grid through a host-chosen number of
// generations. The grid and a shadow next-generation grid are held in
// registers. One cell rule evaluator is shared by all cells: it visits one
// cell per cycle in row-major order, then the shadow is committed in a
// single cycle, so the visible grid never holds a partial generation.
//
// Build option: define LIFE_TORUS_EN for a toroidal grid (edges wrap).
// Without it, off-grid neighbours read as dead and no wrap logic exists.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   wr_en      in   write one cell of the current grid (IDLE only)
//   wr_addr    in   write address, row*W + col
//   wr_data    in   1 = live, 0 = dead
//   rd_addr    in   read address, row*W + col
//   rd_data    out  combinational read of the current grid, 0 off-grid
//   start      in   launch a run (IDLE only)
//   num_gens   in   generations to run, sampled with start, 0 means 1
//   busy       out  high while scanning or committing
//   done       out  one-cycle pulse after the last commit of a run
//   gen_count  out  generations committed since reset, wrapping
//   pop_count  out  live cells in the current grid

module life_grid_seq #(
    parameter int W      = 8,
    parameter int H      = 8,
    parameter int ADDR_W = 6,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data,
    input  logic              start,
    input  logic [7:0]        num_gens,
    output logic              busy,
    output logic              done,
    output logic [GEN_W-1:0]  gen_count,
    output logic [ADDR_W:0]   pop_count
);

    localparam int CELLS = W * H;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int RW    = (H > 1) ? $clog2(H) : 1;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;

    localparam logic [ADDR_W:0]   CELLS_C   = (ADDR_W + 1)'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(CELLS - 1);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(H - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]        r_state;
    logic              r_grid   [DEPTH];
    logic              r_shadow [DEPTH];
    logic [ADDR_W-1:0] r_idx;
    logic [RW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [7:0]        r_remaining;
    logic [ADDR_W:0]   r_live_next;
    logic [ADDR_W:0]   r_pop;
    logic [GEN_W-1:0]  r_gen;
    logic              r_done;

    // Neighbour coordinates around the scanned cell (r_row, r_col). The
    // row/col counters run alongside r_idx so no divider is needed.
    logic [RW-1:0] w_row_m;
    logic [RW-1:0] w_row_p;
    logic [CW-1:0] w_col_m;
    logic [CW-1:0] w_col_p;
    logic          w_up_ok;
    logic          w_dn_ok;
    logic          w_lf_ok;
    logic          w_rt_ok;

`ifdef LIFE_TORUS_EN
    assign w_row_m = (r_row == '0)      ? LAST_ROW : r_row - RW'(1);
    assign w_row_p = (r_row == LAST_ROW) ? '0      : r_row + RW'(1);
    assign w_col_m = (r_col == '0)      ? LAST_COL : r_col - CW'(1);
    assign w_col_p = (r_col == LAST_COL) ? '0      : r_col + CW'(1);
    assign w_up_ok = 1'b1;
    assign w_dn_ok = 1'b1;
    assign w_lf_ok = 1'b1;
    assign w_rt_ok = 1'b1;
`else
    // Out-of-range coordinates wrap in the subtraction, but the matching
    // *_ok flag forces those neighbours to 0 before they reach the adder.
    assign w_row_m = r_row - RW'(1);
    assign w_row_p = r_row + RW'(1);
    assign w_col_m = r_col - CW'(1);
    assign w_col_p = r_col + CW'(1);
    assign w_up_ok = (r_row != '0);
    assign w_dn_ok = (r_row != LAST_ROW);
    assign w_lf_ok = (r_col != '0);
    assign w_rt_ok = (r_col != LAST_COL);
`endif

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] row,
                                                    input logic [CW-1:0] col);
        return ADDR_W'(row) * ADDR_W'(W) + ADDR_W'(col);
    endfunction

    logic [7:0] w_nb;
    logic [3:0] w_n;
    logic       w_self;
    logic       w_next;

    always_comb begin
        w_nb[0] = w_up_ok & w_lf_ok & r_grid[cell_addr(w_row_m, w_col_m)];
        w_nb[1] = w_up_ok           & r_grid[cell_addr(w_row_m, r_col)];
        w_nb[2] = w_up_ok & w_rt_ok & r_grid[cell_addr(w_row_m, w_col_p)];
        w_nb[3] =           w_lf_ok & r_grid[cell_addr(r_row,   w_col_m)];
        w_nb[4] =           w_rt_ok & r_grid[cell_addr(r_row,   w_col_p)];
        w_nb[5] = w_dn_ok & w_lf_ok & r_grid[cell_addr(w_row_p, w_col_m)];
        w_nb[6] = w_dn_ok           & r_grid[cell_addr(w_row_p, r_col)];
        w_nb[7] = w_dn_ok & w_rt_ok & r_grid[cell_addr(w_row_p, w_col_p)];
    end

    // The one shared neighbour adder.
    always_comb begin
        w_n = '0;
        for (int i = 0; i < 8; i++) begin
            w_n = w_n + 4'(w_nb[i]);
        end
    end

    assign w_self = r_grid[r_idx];
    assign w_next = (w_n == 4'd3) | (w_self & (w_n == 4'd2));

    logic w_wr_in_range;
    assign w_wr_in_range = ({1'b0, wr_addr} < CELLS_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_remaining <= '0;
            r_live_next <= '0;
            r_pop       <= '0;
            r_gen       <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_grid[i]   <= 1'b0;
                r_shadow[i] <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_en && w_wr_in_range) begin
                        r_grid[wr_addr] <= wr_data;
                        if (r_grid[wr_addr] != wr_data) begin
                            r_pop <= wr_data ? r_pop + (ADDR_W + 1)'(1)
                                             : r_pop - (ADDR_W + 1)'(1);
                        end
                    end
                    // A same-cycle write lands at this edge, before the
                    // first scan cycle reads the grid.
                    if (start) begin
                        r_remaining <= (num_gens == 8'd0) ? 8'd1 : num_gens;
                        r_idx       <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_live_next <= '0;
                        r_state     <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    r_shadow[r_idx] <= w_next;
                    r_live_next     <= r_live_next + (ADDR_W + 1)'(w_next);
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end

                S_COMMIT: begin
                    for (int i = 0; i < CELLS; i++) begin
                        r_grid[i] <= r_shadow[i];
                    end
                    r_pop       <= r_live_next;
                    r_gen       <= r_gen + GEN_W'(1);
                    r_remaining <= r_remaining - 8'd1;
                    if (r_remaining > 8'd1) begin
                        r_idx       <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_live_next <= '0;
                        r_state     <= S_SCAN;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = ({1'b0, rd_addr} < CELLS_C) ? r_grid[rd_addr] : 1'b0;
    assign busy      = (r_state == S_SCAN) || (r_state == S_COMMIT);
    assign done      = r_done;
    assign gen_count = r_gen;
    assign pop_count = r_pop;

endmodule

// File: tb/tb_life_grid_seq.sv
// tb/tb_life_grid_seq.sv - directed self-checking bench for life_grid_seq

module tb_life_grid_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic        wr_data;
    logic [5:0]  rd_addr;
    logic        rd_data;
    logic        start;
    logic [7:0]  num_gens;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [6:0]  pop_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    life_grid_seq #(.W(8), .H(8), .ADDR_W(6), .GEN_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .start     (start),
        .num_gens  (num_gens),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count),
        .pop_count (pop_count)
    );

    typedef struct {
        string       name;
        logic [63:0] init;
        int          init_pop;
        logic [7:0]  ng;
        logic [63:0] exp_grid;
        int          exp_pop;
        int          exp_gen;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000; // (3,2)(3,3)(3,4)
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000; // (2,3)(3,3)(4,3)
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600; // (1,1)-(2,2)
    localparam logic [63:0] EDGE3   = 64'h0100_0000_0000_0003; // (0,0)(0,1)(7,0)
`ifdef LIFE_TORUS_EN
    localparam logic [63:0] EDGE_EXP = 64'h0300_0000_0000_0003; // wraps to a block
    localparam int          EDGE_POP = 4;
`else
    localparam logic [63:0] EDGE_EXP = 64'h0;
    localparam int          EDGE_POP = 0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_cell(input int addr, input logic val);
        wr_en   = 1'b1;
        wr_addr = 6'(addr);
        wr_data = val;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load(input logic [63:0] g);
        for (int i = 0; i < 64; i++) begin
            if (g[i]) write_cell(i, 1'b1);
        end
    endtask

    task automatic read_grid(output logic [63:0] g);
        g = '0;
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            g[i] = rd_data;
        end
    endtask

    // Returns cycles from the start edge to the done cycle and busy cycles seen.
    task automatic run_gens(input logic [7:0] ng, output int lat, output int bsy);
        num_gens = ng;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        bsy   = 0;
        while (!done && lat < 3000) begin
            if (busy) bsy++;
            tick();
            lat++;
        end
    endtask

    vec_t        vecs [6];
    logic [63:0] g;
    int          lat;
    int          bsy;
    int          pulses;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
        rd_addr = '0; start = 1'b0; num_gens = '0;

        vecs[0] = '{"blinker",    BLINK_H, 3, 8'd1, BLINK_V,  3,        1, 66,  65};
        vecs[1] = '{"block5",     BLOCK,   4, 8'd5, BLOCK,    4,        5, 326, 325};
        vecs[2] = '{"edge",       EDGE3,   3, 8'd1, EDGE_EXP, EDGE_POP, 1, 66,  65};
        vecs[3] = '{"gens0",      BLINK_H, 3, 8'd0, BLINK_V,  3,        1, 66,  65};
        vecs[4] = '{"blinker2",   BLINK_H, 3, 8'd2, BLINK_H,  3,        2, 131, 130};
        vecs[5] = '{"lonely",     64'h0000_0010_0000_0000, 1, 8'd1, 64'h0, 0, 1, 66, 65};

        // Reset state.
        tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_gen",  64'(gen_count), 0);
        chk("rst_pop",  64'(pop_count), 0);
        rst = 1'b0;
        read_grid(g);
        chk("rst_grid", g, 64'h0);

        // Population tracking on redundant writes.
        write_cell(5, 1'b1);
        chk("pop_set", 64'(pop_count), 1);
        write_cell(5, 1'b1);
        chk("pop_same1", 64'(pop_count), 1);
        write_cell(5, 1'b0);
        chk("pop_clear", 64'(pop_count), 0);
        write_cell(5, 1'b0);
        chk("pop_same0", 64'(pop_count), 0);

        // Table of full runs from reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            load(vecs[v].init);
            chk({vecs[v].name, "_loadpop"}, 64'(pop_count), 64'(vecs[v].init_pop));
            run_gens(vecs[v].ng, lat, bsy);
            chk({vecs[v].name, "_lat"},  64'(lat), 64'(vecs[v].exp_lat));
            chk({vecs[v].name, "_busy"}, 64'(bsy), 64'(vecs[v].exp_busy));
            chk({vecs[v].name, "_busy_at_done"}, 64'(busy), 0);
            chk({vecs[v].name, "_pop"},  64'(pop_count), 64'(vecs[v].exp_pop));
            chk({vecs[v].name, "_gen"},  64'(gen_count), 64'(vecs[v].exp_gen));
            tick();
            chk({vecs[v].name, "_done_1cyc"}, 64'(done), 0);
            read_grid(g);
            chk({vecs[v].name, "_grid"}, g, vecs[v].exp_grid);
        end

        // Writes and starts during a run are ignored; grid shows old generation.
        do_reset();
        load(BLINK_H);
        num_gens = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 9; i++) tick();
        wr_en = 1'b1; wr_addr = 6'd45; wr_data = 1'b1; start = 1'b1;
        rd_addr = 6'd26;
        #1;
        chk("hs_rd_old_grid", 64'(rd_data), 1);
        tick();
        wr_en = 1'b0; start = 1'b0;
        for (int i = 0; i < 250; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("hs_done_pulses", 64'(pulses), 1);
        chk("hs_busy_end", 64'(busy), 0);
        chk("hs_gen", 64'(gen_count), 1);
        chk("hs_pop", 64'(pop_count), 3);
        read_grid(g);
        chk("hs_grid", g, BLINK_V);

        // Reset mid-run from a state with nonzero counters.
        rd_addr = 6'd27;
        num_gens = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 29; i++) tick();
        chk("mr_busy_before", 64'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_busy", 64'(busy), 0);
        chk("mr_done", 64'(done), 0);
        chk("mr_gen",  64'(gen_count), 0);
        chk("mr_pop",  64'(pop_count), 0);
        chk("mr_cell", 64'(rd_data), 0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        chk("mr_no_activity", 64'(pulses), 0);
        read_grid(g);
        chk("mr_grid", g, 64'h0);
        load(BLINK_H);
        run_gens(8'd1, lat, bsy);
        chk("mr_rerun_lat", 64'(lat), 66);
        chk("mr_rerun_pop", 64'(pop_count), 3);
        chk("mr_rerun_gen", 64'(gen_count), 1);
        tick();
        read_grid(g);
        chk("mr_rerun_grid", g, BLINK_V);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
